mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the RV32I pipeline. It sits between the EX_MEM pipeline register and the MEM_WB register.
- Performs loads and stores on a handshaked data-memory port, which may take several cycles. Formats load data (byte/half extract, sign/zero extension) and forwards write-back controls and the ALU result.
- Raises a stall while an access is outstanding. Buffers completed load data if the hazard unit holds the pipeline.

Parameters:
TIMEOUT, 15, cycles to wait for dmem_ack before forcing completion with bus_err; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mem_rd_in  in  1  load request from EX_MEM
mem_wr_in  in  1  store request from EX_MEM
funct3_in  in  3  access width/sign (RV32I load/store funct3)
ula_res_in  in  32  ALU result = byte address; forwarded as ula_res_out
store_data_in  in  32  rs2 value for stores
reg_wr_in  in  1  write-back enable
mux_reg_wr_in  in  1  write-back select (1 = memory result)
hold  in  1  external pipeline freeze from hazard unit
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {ula_res_in[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete (may be high in the same cycle as dmem_req)
dmem_rdata  in  32  read word, valid when dmem_ack=1
stall  out  1  freezes PC/IF_ID/ID_EX/EX_MEM; drives MEM_WB enable as !stall && !hold
reg_wr_out  out  1  write-back enable to MEM_WB
mux_reg_wr_out  out  1  pass-through
ula_res_out  out  32  pass-through
mem_res_out  out  32  formatted load data
misalign  out  1  misaligned access detected this cycle
bus_err  out  1  one-cycle pulse on timeout completion

Behaviour:
- States: IDLE, WAIT, DONE. A timeout counter cnt has width clog2(TIMEOUT+1). A 32-bit load buffer is lb_q. rst forces state=IDLE, cnt=0, lb_q=0, bus_err=0.
- Outputs during rst: all outputs are 0 except the pass-throughs, which follow their inputs.
- acc = mem_rd_in | mem_wr_in. If both are set, the access is treated as a store.
- misalign (combinational, only when acc):
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - funct3 values 011, 110, 111 count as misaligned.
- On misalign: no request, stall=0, reg_wr_out=0, mem_res_out=0.
- IDLE, with acc and no misalign:
  - dmem_req=1 combinationally.
  - If dmem_ack=1 in the same cycle: completes with zero wait states and stall=0. Goes to DONE if (hold and load), else stays IDLE.
  - If dmem_ack=0: goes to WAIT and stall=1.
- WAIT:
  - dmem_req=1 and stall=1. Address, data and enables stay stable because EX_MEM is frozen. cnt increments each cycle.
  - On dmem_ack=1: stall=0 that cycle. Goes to DONE if hold=1, else IDLE.
  - If TIMEOUT!=0 and cnt==TIMEOUT-1 without ack: stall=0 and bus_err=1 for that cycle. A load returns 0 and reg_wr_out=0. Next state as on ack.
  - cnt clears on leaving WAIT.
- lb_q capture: on the completing cycle of a load, lb_q <= formatted rdata.
- DONE:
  - dmem_req=0 (no re-issue). mem_res_out=lb_q. stall=0.
  - Returns to IDLE on the first cycle with hold=0; the same edge loads MEM_WB.
  - A store never enters DONE, because its completion has no data to keep.
- Load formatting (mem_res_out in IDLE/WAIT, from dmem_rdata):
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB (000) sign-extends, LBU (100) zero-extends.
  - LH (001) sign-extends, LHU (101) zero-extends.
  - LW (010) passes the word.
  - Non-load or no ack gives 0.
- Store formatting:
  - SB: wdata={4{b}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, be=addr[1]?1100:0011.
  - SW: be=1111.
  - A load drives be=1111 and we=0.
- reg_wr_out = reg_wr_in, except forced 0 on misalign and on a load timeout.
- Asynchronous rst mid-WAIT abandons the access immediately: state returns to IDLE and dmem_req drops in the same cycle.

Decomposition:
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, and a clog2-based counter width function.
- Sub-module load_formatter: combinational; inputs rdata, addr[1:0], funct3; output is the extended 32-bit word. It is shared with the future forwarding path.

Test Plan:
- LW addr 0x100, ack in the same cycle, rdata 0xDEADBEEF -> stall never 1; mem_res_out=0xDEADBEEF; be=1111.
- LB addr 0x103, ack after 3 cycles, rdata 0x80FF1234 -> stall high 3 cycles; mem_res_out=0xFFFFFF80. LBU with the same stimulus -> 0x00000080.
- SH addr 0x202, data 0x0000ABCD, ack after 1 cycle -> wdata=0xABCDABCD; be=1100; we=1; one stall cycle.
- LW addr 0x101 -> misalign=1; dmem_req=0; reg_wr_out=0; stall=0.
- LW with hold=1 at ack (rdata 0x12345678), hold kept 2 more cycles -> state DONE; single dmem_req assertion only; mem_res_out=0x12345678 until hold drops, then IDLE.
- No ack with TIMEOUT=15 -> stall for 14 cycles; cycle 15 has bus_err=1, stall=0, reg_wr_out=0. Assert rst mid-WAIT -> dmem_req=0 immediately; state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state type and counter sizing for the memory stage
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    function automatic int cnt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction
endpackage

// File: rtl/load_formatter.sv
// load_formatter: lane extraction and sign/zero extension of a read word
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'(rdata >> {addr, 3'b000});
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        data = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_BU ? {24'b0, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_HU ? {16'b0, h} :
               funct3 == F3_W  ? rdata : 32'b0;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with handshaked data port, stall,
// timeout completion and load buffering while the pipeline is held
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_in,
    input  logic        mem_wr_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ula_res_in,
    input  logic [31:0] store_data_in,
    input  logic        reg_wr_in,
    input  logic        mux_reg_wr_in,
    input  logic        hold,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        reg_wr_out,
    output logic        mux_reg_wr_out,
    output logic [31:0] ula_res_out,
    output logic [31:0] mem_res_out,
    output logic        misalign,
    output logic        bus_err
);
    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   lb_q, fmt;
    logic          to_q;
    logic          acc, load, mis, go, to, fin, keep;

    load_formatter u_fmt (
        .rdata  (dmem_rdata),
        .addr   (ula_res_in[1:0]),
        .funct3 (funct3_in),
        .data   (fmt)
    );

    always_comb begin
        acc = mem_rd_in | mem_wr_in;
        load = mem_rd_in & ~mem_wr_in;
        mis = acc && (funct3_in inside {3'b011, 3'b110, 3'b111} ||
                      (funct3_in[1:0] == 2'b01 && ula_res_in[0]) ||
                      (funct3_in[1:0] == 2'b10 && ula_res_in[1:0] != 2'b00));
        go = acc && !mis;
        // cnt counts the request cycle too, so the timeout lands on access cycle TIMEOUT
        to = (TIMEOUT != 0) && state == WAIT && !dmem_ack && cnt >= TO_LAST;
        fin = (state == IDLE && go && dmem_ack) || (state == WAIT && (dmem_ack || to));
        keep = hold && load;
        state_n = fin ? (keep ? DONE : IDLE) :
                  state == IDLE ? (go ? WAIT : IDLE) :
                  state == DONE ? (hold ? DONE : IDLE) : WAIT;
    end

    assign dmem_req = !rst && ((state == IDLE && go) || state == WAIT);
    assign dmem_we = dmem_req && mem_wr_in;
    assign dmem_addr = rst ? 32'b0 : {ula_res_in[31:2], 2'b00};
    assign dmem_wdata = rst ? 32'b0 :
                        funct3_in[1:0] == 2'b00 ? {4{store_data_in[7:0]}} :
                        funct3_in[1:0] == 2'b01 ? {2{store_data_in[15:0]}} : store_data_in;
    assign dmem_be = !dmem_req ? 4'b0000 :
                     !mem_wr_in ? 4'b1111 :
                     funct3_in[1:0] == 2'b00 ? 4'b0001 << ula_res_in[1:0] :
                     funct3_in[1:0] == 2'b01 ? (ula_res_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign stall = dmem_req && !fin;
    assign misalign = !rst && mis;
    assign bus_err = !rst && to;
    assign reg_wr_out = !rst && reg_wr_in && !mis && !(load && to) && !(state == DONE && to_q);
    assign mem_res_out = rst ? 32'b0 :
                         state == DONE ? lb_q :
                         (load && go && dmem_ack) ? fmt : 32'b0;
    assign ula_res_out = ula_res_in;
    assign mux_reg_wr_out = mux_reg_wr_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            lb_q <= '0;
            to_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= state_n != WAIT ? '0 : state == WAIT ? cnt + 1'b1 : CW'(1);
            if (fin && load) begin
                lb_q <= to ? 32'b0 : fmt;
                to_q <= to;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with hand-computed expectations for mem_stage
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in, hold, dmem_ack;
    logic [2:0]  funct3_in;
    logic [31:0] ula_res_in, store_data_in, dmem_rdata;
    logic        dmem_req, dmem_we, stall, reg_wr_out, mux_reg_wr_out, misalign, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, ula_res_out, mem_res_out;
    logic [3:0]  dmem_be;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .funct3_in(funct3_in), .ula_res_in(ula_res_in), .store_data_in(store_data_in),
        .reg_wr_in(reg_wr_in), .mux_reg_wr_in(mux_reg_wr_in), .hold(hold),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall), .reg_wr_out(reg_wr_out),
        .mux_reg_wr_out(mux_reg_wr_out), .ula_res_out(ula_res_out),
        .mem_res_out(mem_res_out), .misalign(misalign), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
        mem_rd_in = rd;
        mem_wr_in = wr;
        funct3_in = f3;
        ula_res_in = a;
        store_data_in = d;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        hold = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rd, input logic [31:0] exp, input int waits);
        int st = 0;
        op(1'b1, 1'b0, f3, a, 32'h0);
        reg_wr_in = 1'b1;
        for (int i = 0; i < waits; i++) begin
            #1;
            st += int'(stall);
            if (i == 0) chk({tag, "_res_nack"}, mem_res_out, 32'h0);
            step();
        end
        dmem_ack = 1'b1;
        dmem_rdata = rd;
        #1;
        chk({tag, "_stalls"}, 32'(st), 32'(waits));
        chk({tag, "_stall_ack"}, 32'(stall), 32'h0);
        chk({tag, "_res"}, mem_res_out, exp);
        chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, "_be"}, 32'(dmem_be), 32'hf);
        chk({tag, "_we"}, 32'(dmem_we), 32'h0);
        chk({tag, "_regwr"}, 32'(reg_wr_out), 32'h1);
        step();
        idle();
    endtask

    initial begin
        int st, be_cnt;
        idle();
        reg_wr_in = 1'b1;
        mux_reg_wr_in = 1'b1;
        op(1'b1, 1'b0, F3_W, 32'h104, 32'h0);
        dmem_ack = 1'b1;
        #3;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_res", mem_res_out, 32'h0);
        chk("rst_regwr", 32'(reg_wr_out), 32'h0);
        chk("rst_ula_pass", ula_res_out, 32'h104);
        chk("rst_mux_pass", 32'(mux_reg_wr_out), 32'h1);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        step();
        rst = 1'b0;
        idle();
        step();

        load_case("lw0", F3_W, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        load_case("lb3", F3_B, 32'h103, 32'h80FF1234, 32'hFFFFFF80, 3);
        load_case("lbu3", F3_BU, 32'h103, 32'h80FF1234, 32'h00000080, 3);
        load_case("lb1", F3_B, 32'h101, 32'h80FF1234, 32'h00000012, 0);
        load_case("lh2", F3_H, 32'h102, 32'h80FF1234, 32'hFFFF80FF, 1);
        load_case("lhu2", F3_HU, 32'h102, 32'h80FF1234, 32'h000080FF, 0);

        reg_wr_in = 1'b0;
        op(1'b0, 1'b1, F3_H, 32'h202, 32'h0000ABCD);
        #1;
        chk("sh_stall", 32'(stall), 32'h1);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_be", 32'(dmem_be), 32'hc);
        chk("sh_we", 32'(dmem_we), 32'h1);
        step();
        dmem_ack = 1'b1;
        #1;
        chk("sh_stall_ack", 32'(stall), 32'h0);
        chk("sh_req_wait", 32'(dmem_req), 32'h1);
        step();
        idle();
        #1;
        chk("sh_state", 32'(dut.state), 32'(IDLE));

        op(1'b0, 1'b1, F3_B, 32'h201, 32'h000012EF);
        dmem_ack = 1'b1;
        #1;
        chk("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_stall", 32'(stall), 32'h0);
        step();
        idle();

        reg_wr_in = 1'b1;
        op(1'b1, 1'b0, F3_W, 32'h101, 32'h0);
        #1;
        chk("mis_lw", 32'(misalign), 32'h1);
        chk("mis_req", 32'(dmem_req), 32'h0);
        chk("mis_regwr", 32'(reg_wr_out), 32'h0);
        chk("mis_stall", 32'(stall), 32'h0);
        op(1'b1, 1'b0, F3_H, 32'h103, 32'h0);
        #1;
        chk("mis_lh", 32'(misalign), 32'h1);
        op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        chk("mis_f3", 32'(misalign), 32'h1);
        op(1'b1, 1'b0, F3_H, 32'h102, 32'h0);
        #1;
        chk("mis_ok", 32'(misalign), 32'h0);
        idle();
        step();

        op(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
        hold = 1'b1;
        #1;
        chk("hold_stall", 32'(stall), 32'h1);
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        #1;
        chk("hold_stall_ack", 32'(stall), 32'h0);
        step();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_state", 32'(dut.state), 32'(DONE));
            chk("hold_req", 32'(dmem_req), 32'h0);
            chk("hold_res", mem_res_out, 32'h12345678);
            step();
        end
        hold = 1'b0;
        #1;
        chk("hold_res_rel", mem_res_out, 32'h12345678);
        step();
        idle();
        #1;
        chk("hold_idle", 32'(dut.state), 32'(IDLE));

        st = 0;
        be_cnt = 0;
        op(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
        for (int c = 1; c <= 15; c++) begin
            #1;
            if (c < 15) begin
                st += int'(stall);
                be_cnt += int'(bus_err);
            end else begin
                chk("to_err", 32'(bus_err), 32'h1);
                chk("to_stall", 32'(stall), 32'h0);
                chk("to_regwr", 32'(reg_wr_out), 32'h0);
                chk("to_res", mem_res_out, 32'h0);
            end
            step();
        end
        chk("to_stalls", 32'(st), 32'd14);
        chk("to_early_err", 32'(be_cnt), 32'h0);
        idle();
        #1;
        chk("to_err_pulse", 32'(bus_err), 32'h0);
        chk("to_state", 32'(dut.state), 32'(IDLE));

        op(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
        step();
        step();
        chk("arst_pre_req", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(dmem_req), 32'h0);
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        chk("arst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        idle();
        step();
        chk("arst_idle", 32'(dut.state), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
